// File: rtl/buffer_ctrl.sv
// buffer_ctrl: pointer/occupancy controller for a circular parallel-write, parallel-read line buffer.
// Optional synchronous flush port when BUF_CTRL_FLUSH_EN is defined. Revision: 1.0
`default_nettype none

module buffer_ctrl #(
  parameter int SIZE        = 16,
  parameter int MEM_SIZE    = 8,
  parameter int PAR_WRITE   = 4,
  parameter int PAR_READ    = 2,
  parameter int STRIDE      = 1,
  parameter int ADDRES_SIZE = $clog2(MEM_SIZE),
  parameter int CNT_SIZE    = $clog2(MEM_SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   wen,
  output logic [ADDRES_SIZE-1:0] waddr,
  output logic [ADDRES_SIZE-1:0] raddr,
  output logic [CNT_SIZE-1:0]    count
`ifdef BUF_CTRL_FLUSH_EN
  ,
  input  logic                   flush
`endif
);

  localparam logic [ADDRES_SIZE:0] c_MEM_A   = (ADDRES_SIZE+1)'(MEM_SIZE);
  localparam logic [ADDRES_SIZE:0] c_PW_A    = (ADDRES_SIZE+1)'(PAR_WRITE);
  localparam logic [ADDRES_SIZE:0] c_ST_A    = (ADDRES_SIZE+1)'(STRIDE);
  localparam logic [CNT_SIZE:0]    c_MEM_C   = (CNT_SIZE+1)'(MEM_SIZE);
  localparam logic [CNT_SIZE:0]    c_PW_CX   = (CNT_SIZE+1)'(PAR_WRITE);
  localparam logic [CNT_SIZE-1:0]  c_PW_C    = CNT_SIZE'(PAR_WRITE);
  localparam logic [CNT_SIZE-1:0]  c_ST_C    = CNT_SIZE'(STRIDE);
  localparam logic [CNT_SIZE-1:0]  c_PR_C    = CNT_SIZE'(PAR_READ);

  generate
    if (SIZE < 1 || STRIDE < 1 || STRIDE > PAR_READ || PAR_WRITE > MEM_SIZE || PAR_READ > MEM_SIZE)
    begin : g_bad_params
      $error("buffer_ctrl: illegal parameter combination");
    end
  endgenerate

  logic [ADDRES_SIZE-1:0] r_wptr;
  logic [ADDRES_SIZE-1:0] r_rptr;
  logic [CNT_SIZE-1:0]    r_count;

  logic                   w_flush;
  logic                   w_wr;
  logic                   w_rd;
  logic [ADDRES_SIZE:0]   w_wsum;
  logic [ADDRES_SIZE:0]   w_rsum;
  logic [ADDRES_SIZE:0]   w_wwrap;
  logic [ADDRES_SIZE:0]   w_rwrap;

`ifdef BUF_CTRL_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Space check uses only the registered count; a same-cycle read never frees room early.
  assign in_ready  = ({1'b0, r_count} + c_PW_CX) <= c_MEM_C;
  assign out_valid = r_count >= c_PR_C;
  assign wen       = in_valid & in_ready & ~w_flush;
  assign w_wr      = wen;
  assign w_rd      = out_valid & out_ready;

  // One extra bit holds ptr+step without overflow, so a single subtract wraps any MEM_SIZE.
  assign w_wsum  = {1'b0, r_wptr} + c_PW_A;
  assign w_rsum  = {1'b0, r_rptr} + c_ST_A;
  assign w_wwrap = (w_wsum >= c_MEM_A) ? (w_wsum - c_MEM_A) : w_wsum;
  assign w_rwrap = (w_rsum >= c_MEM_A) ? (w_rsum - c_MEM_A) : w_rsum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= w_wwrap[ADDRES_SIZE-1:0];
      if (w_rd) r_rptr <= w_rwrap[ADDRES_SIZE-1:0];
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + c_PW_C;
        2'b01:   r_count <= r_count - c_ST_C;
        2'b11:   r_count <= r_count + c_PW_C - c_ST_C;
        default: r_count <= r_count;
      endcase
    end
  end

  assign waddr = r_wptr;
  assign raddr = r_rptr;
  assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_buffer_ctrl.sv
// tb_buffer_ctrl: table vectors, corner sequences and random traffic against a reference model,
// driving a STRIDE=1 and a STRIDE=2 instance in parallel.
`default_nettype none

module tb_buffer_ctrl;
  localparam int MEM = 8;
  localparam int PW  = 4;
  localparam int PR  = 2;
  localparam int AW  = $clog2(MEM);
  localparam int CW  = $clog2(MEM + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [1:0] ir_v, ov_v, wen_v;
  logic [AW-1:0] waddr_v [2];
  logic [AW-1:0] raddr_v [2];
  logic [CW-1:0] count_v [2];
`ifdef BUF_CTRL_FLUSH_EN
  logic flush = 1'b0;
`endif

  always #5 clk = ~clk;

  buffer_ctrl #(.SIZE(16), .MEM_SIZE(MEM), .PAR_WRITE(PW), .PAR_READ(PR), .STRIDE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_v[0]), .out_valid(ov_v[0]),
    .out_ready(out_ready), .wen(wen_v[0]), .waddr(waddr_v[0]), .raddr(raddr_v[0]), .count(count_v[0])
`ifdef BUF_CTRL_FLUSH_EN
    , .flush(flush)
`endif
  );

  buffer_ctrl #(.SIZE(16), .MEM_SIZE(MEM), .PAR_WRITE(PW), .PAR_READ(PR), .STRIDE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_v[1]), .out_valid(ov_v[1]),
    .out_ready(out_ready), .wen(wen_v[1]), .waddr(waddr_v[1]), .raddr(raddr_v[1]), .count(count_v[1])
`ifdef BUF_CTRL_FLUSH_EN
    , .flush(flush)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: occupancy and pointers as plain integers, modulo arithmetic.
  int m_cnt [2];
  int m_wp  [2];
  int m_rp  [2];
  int m_st  [2] = '{1, 2};

  typedef struct {
    bit iv; bit ordy; bit wen;
    int cnt; int wa; int ra; bit ir; bit ov;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_wp[i] = 0; m_rp[i] = 0;
    end
  endtask

  task automatic model_check(input int i, input bit iv, input bit fl);
    bit e_ir, e_ov;
    e_ir = (m_cnt[i] + PW) <= MEM;
    e_ov = m_cnt[i] >= PR;
    chk($sformatf("m%0d_in_ready", i), 32'(ir_v[i]), 32'(e_ir));
    chk($sformatf("m%0d_out_valid", i), 32'(ov_v[i]), 32'(e_ov));
    chk($sformatf("m%0d_wen", i), 32'(wen_v[i]), 32'(iv && e_ir && !fl));
    chk($sformatf("m%0d_count", i), 32'(count_v[i]), 32'(m_cnt[i]));
    chk($sformatf("m%0d_waddr", i), 32'(waddr_v[i]), 32'(m_wp[i]));
    chk($sformatf("m%0d_raddr", i), 32'(raddr_v[i]), 32'(m_rp[i]));
  endtask

  task automatic model_edge(input int i, input bit iv, input bit ordy, input bit fl);
    bit wr, rd;
    wr = iv && ((m_cnt[i] + PW) <= MEM) && !fl;
    rd = ordy && (m_cnt[i] >= PR) && !fl;
    if (fl) begin
      m_cnt[i] = 0; m_wp[i] = 0; m_rp[i] = 0;
    end else begin
      if (wr) begin m_wp[i] = (m_wp[i] + PW) % MEM; m_cnt[i] += PW; end
      if (rd) begin m_rp[i] = (m_rp[i] + m_st[i]) % MEM; m_cnt[i] -= m_st[i]; end
    end
  endtask

  // Called at posedge+1; leaves time at the next posedge+1.
  task automatic step(input bit iv, input bit ordy, input bit fl, output logic [1:0] wen_s);
    in_valid  = iv;
    out_ready = ordy;
`ifdef BUF_CTRL_FLUSH_EN
    flush = fl;
`endif
    #3;
    wen_s = wen_v;
    for (int i = 0; i < 2; i++) model_check(i, iv, fl);
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i, iv, ordy, fl);
    #1;
  endtask

  // Asynchronous reset dropped between edges; outputs must clear before the next edge.
  task automatic async_reset();
    in_valid = 1'b0; out_ready = 1'b0;
`ifdef BUF_CTRL_FLUSH_EN
    flush = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_count", i), 32'(count_v[i]), 0);
      chk($sformatf("rst%0d_waddr", i), 32'(waddr_v[i]), 0);
      chk($sformatf("rst%0d_raddr", i), 32'(raddr_v[i]), 0);
      chk($sformatf("rst%0d_in_ready", i), 32'(ir_v[i]), 1);
      chk($sformatf("rst%0d_out_valid", i), 32'(ov_v[i]), 0);
      chk($sformatf("rst%0d_wen", i), 32'(wen_v[i]), 0);
    end
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ws;
    bit fl;

    tbl[0]  = '{1, 1, 1, 4, 4, 0, 1, 1};
    tbl[1]  = '{1, 0, 1, 8, 0, 0, 0, 1};
    tbl[2]  = '{1, 0, 0, 8, 0, 0, 0, 1};
    for (int k = 1; k <= 7; k++)
      tbl[2+k] = '{0, 1, 0, 8 - k, 0, k, (8 - k) <= 4, (8 - k) >= 2};
    tbl[10] = '{0, 1, 0, 1, 0, 7, 1, 0};
    tbl[11] = '{1, 0, 1, 5, 4, 7, 0, 1};
    tbl[12] = '{1, 1, 0, 4, 4, 0, 1, 1};
    tbl[13] = '{1, 1, 1, 7, 0, 1, 0, 1};

    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 0, 0, ws);
    async_reset();

    for (int v = 0; v < 14; v++) begin
      step(tbl[v].iv, tbl[v].ordy, 1'b0, ws);
      chk($sformatf("tbl%0d_wen", v), 32'(ws[0]), 32'(tbl[v].wen));
      chk($sformatf("tbl%0d_count", v), 32'(count_v[0]), 32'(tbl[v].cnt));
      chk($sformatf("tbl%0d_waddr", v), 32'(waddr_v[0]), 32'(tbl[v].wa));
      chk($sformatf("tbl%0d_raddr", v), 32'(raddr_v[0]), 32'(tbl[v].ra));
      chk($sformatf("tbl%0d_in_ready", v), 32'(ir_v[0]), 32'(tbl[v].ir));
      chk($sformatf("tbl%0d_out_valid", v), 32'(ov_v[0]), 32'(tbl[v].ov));
    end

    // STRIDE=2 read pointer wrap from raddr 6.
    async_reset();
    step(1, 0, 0, ws); step(0, 1, 0, ws); step(1, 0, 0, ws);
    step(0, 1, 0, ws); step(0, 1, 0, ws);
    chk("s2_pre_raddr", 32'(raddr_v[1]), 6);
    chk("s2_pre_count", 32'(count_v[1]), 2);
    step(0, 1, 0, ws);
    chk("s2_wrap_raddr", 32'(raddr_v[1]), 0);
    chk("s2_wrap_count", 32'(count_v[1]), 0);

`ifdef BUF_CTRL_FLUSH_EN
    async_reset();
    step(1, 0, 0, ws); step(0, 1, 0, ws); step(0, 1, 0, ws); step(1, 0, 0, ws);
    chk("fl_pre_count", 32'(count_v[0]), 6);
    step(1, 1, 1, ws);
    chk("fl_wen", 32'(ws[0]), 0);
    chk("fl_count", 32'(count_v[0]), 0);
    chk("fl_waddr", 32'(waddr_v[0]), 0);
    chk("fl_raddr", 32'(raddr_v[0]), 0);
    chk("fl_in_ready", 32'(ir_v[0]), 1);
    chk("fl_out_valid", 32'(ov_v[0]), 0);
`endif

    async_reset();
    for (int n = 0; n < 400; n++) begin
      fl = 1'b0;
`ifdef BUF_CTRL_FLUSH_EN
      fl = ($urandom_range(0, 31) == 0);
`endif
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, fl, ws);
      if (n == 200) async_reset();
    end
    step(0, 0, 0, ws);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/buffer_ctrl.md
Name: buffer_ctrl

Overview:
- Pointer and handshake controller for the circular parallel-write / parallel-read line buffer.
- Sits between the upstream producer (PAR_WRITE words per beat) and the buffer, and between the buffer and the downstream consumer (PAR_READ-word window).
- Drives the buffer's wen, waddr and raddr, and tracks occupancy.
- Converts the two valid/ready streams into buffer accesses, advancing the read window by STRIDE words per accepted read.

Parameters:
- SIZE, 16, word width (documentation only; no data passes through this block)
- MEM_SIZE, 8, buffer depth in words
- PAR_WRITE, 4, words written per accepted input beat
- PAR_READ, 2, words presented per read window
- STRIDE, 1, words retired per accepted read; legal range 1..PAR_READ
- ADDRES_SIZE, $clog2(MEM_SIZE), buffer address width
- CNT_SIZE, $clog2(MEM_SIZE+1), occupancy width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has PAR_WRITE words on the buffer din
- in_ready  output  1  space for PAR_WRITE words
- out_valid  output  1  buffer dout holds a full PAR_READ window
- out_ready  input  1  consumer takes the current window
- wen  output  1  buffer write enable
- waddr  output  ADDRES_SIZE  buffer write base address
- raddr  output  ADDRES_SIZE  buffer read base address
- count  output  CNT_SIZE  words currently held
- flush  input  1  present only with BUF_CTRL_FLUSH_EN

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low: rst_n low immediately forces all state to reset values, regardless of clk.
- Reset values:
  - wptr=0, rptr=0, count=0
  - hence waddr=0, raddr=0, in_ready=1, out_valid=0, wen=0
- Outputs:
  - waddr=wptr and raddr=rptr are registered.
  - in_ready = (count + PAR_WRITE <= MEM_SIZE), from registered count only. A read in the same cycle does not free space early (no bypass).
  - out_valid = (count >= PAR_READ).
  - wen = in_valid & in_ready, combinational. The buffer captures din at the same edge.
- Write accept (wr = in_valid & in_ready) at the edge: wptr <= (wptr + PAR_WRITE) mod MEM_SIZE.
- Read accept (rd = out_valid & out_ready) at the edge: rptr <= (rptr + STRIDE) mod MEM_SIZE.
- Pointer arithmetic: compute in ADDRES_SIZE+1 bits, then subtract MEM_SIZE if the sum is >= MEM_SIZE. The result must also be correct for non-power-of-two MEM_SIZE.
- count update per edge:
  - wr only: +PAR_WRITE
  - rd only: -STRIDE
  - both: +PAR_WRITE-STRIDE
  - neither: hold
- count never exceeds MEM_SIZE and never goes negative; this is guaranteed by the in_ready and out_valid conditions.
- Latency:
  - Written words are readable the cycle after acceptance. out_valid may rise that cycle, since the buffer write and the count update land at the same edge.
  - The read window is combinational from raddr, so data is valid whenever out_valid is high.
- Stream rules:
  - in_valid held without in_ready: no wen, no state change.
  - out_ready without out_valid: ignored.
- Window semantics: with STRIDE < PAR_READ, consecutive windows overlap by PAR_READ-STRIDE words (sliding window).
- Reset mid-operation: all state is discarded; buffer contents are stale but unreachable because count=0.

Optional Feature:
- Macro: BUF_CTRL_FLUSH_EN.
- When defined, the flush port exists. A synchronous flush=1 at an edge sets wptr=0, rptr=0, count=0, overriding any wr or rd in that cycle.
  - wen is forced 0 while flush=1.
  - in_ready and out_valid follow from the new state on the next cycle.
- When not defined, the port and logic are absent, and the only way to clear state is rst_n.

Test Plan:
- Reset: rst_n low asynchronously mid-cycle -> count=0, waddr=0, raddr=0, in_ready=1, out_valid=0 before the next clk edge.
- Fill (defaults): two accepted writes ->
  - after the 1st: count=4, waddr=4, out_valid=1
  - after the 2nd: count=8, waddr=0 (wrap), in_ready=0
  - a 3rd in_valid produces no wen and count stays 8.
- Drain with STRIDE=1 from count=8, out_ready held: 7 reads -> raddr steps 1..7, count=1, out_valid=0. Windows read (0,1),(1,2),...,(6,7).
- Simultaneous: count=4, raddr=0, waddr=4, in_valid=out_ready=1 -> next cycle count=7, waddr=0, raddr=1.
- Read wrap with STRIDE=2: raddr=6, count>=2, one read -> raddr=0, count-=2. Window at raddr=7 (STRIDE=1 build) reads words 7,0.
- BUF_CTRL_FLUSH_EN: count=6, flush=1 together with in_valid and out_ready -> wen=0 that cycle; next cycle count=0, waddr=0, raddr=0, in_ready=1, out_valid=0.
